// File: rtl/uart_cmd_parser_if.sv
// Received-byte stream from the UART receiver into the command parser.
// A byte is presented on rx_data together with a single-cycle rx_valid strobe.
interface uart_cmd_parser_if;
   logic [7:0] rx_data;
   logic       rx_valid;

   modport master (
      output rx_data,
      output rx_valid
   );

   modport slave (
      input rx_data,
      input rx_valid
   );
endinterface

// File: rtl/uart_cmd_parser.sv
// Decodes 4-byte command frames (header, cmd, data, checksum) from the UART byte stream.
// Valid frames update the board control registers; errors are pulsed and counted.
module uart_cmd_parser #(
   parameter logic [7:0]  HEADER         = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 9600,
   parameter int unsigned CNT_W          = 14
) (
   input  logic                    clk_in,
   input  logic                    reset,
   uart_cmd_parser_if.slave        rx,
   output logic [7:0]              sw_out,
   output logic [7:0]              chan_mask,
   output logic [1:0]              gate_sel,
   output logic                    cmd_ok,
   output logic                    cmd_err,
   output logic [7:0]              err_count
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] GET_CMD  = 2'd1;
   localparam logic [1:0] GET_DATA = 2'd2;
   localparam logic [1:0] GET_SUM  = 2'd3;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       cmd_q, cmd_d;
   logic [7:0]       data_q, data_d;
   logic [7:0]       sw_q, sw_d;
   logic [7:0]       mask_q, mask_d;
   logic [1:0]       gate_q, gate_d;
   logic             ok_q, ok_d;
   logic             err_q, err_d;
   logic [7:0]       errcnt_q, errcnt_d;
   logic [7:0]       sum_exp;

   assign sum_exp = cmd_q + data_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cmd_d    = cmd_q;
      data_d   = data_q;
      sw_d     = sw_q;
      mask_d   = mask_q;
      gate_d   = gate_q;
      ok_d     = 1'b0;
      err_d    = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (rx.rx_valid && (rx.rx_data == HEADER)) begin
               state_d = GET_CMD;
            end
         end
         default: begin
            // An arriving byte takes priority over an expiring timeout.
            if (rx.rx_valid) begin
               cnt_d = '0;
               case (state_q)
                  GET_CMD: begin
                     cmd_d   = rx.rx_data;
                     state_d = GET_DATA;
                  end
                  GET_DATA: begin
                     data_d  = rx.rx_data;
                     state_d = GET_SUM;
                  end
                  default: begin
                     state_d = IDLE;
                     if (rx.rx_data == sum_exp) begin
                        case (cmd_q)
                           8'h00: ok_d = 1'b1;
                           8'h01: begin
                              sw_d = data_q;
                              ok_d = 1'b1;
                           end
                           8'h02: begin
                              mask_d = data_q;
                              ok_d   = 1'b1;
                           end
                           8'h03: begin
                              gate_d = data_q[1:0];
                              ok_d   = 1'b1;
                           end
                           default: err_d = 1'b1;
                        endcase
                     end else begin
                        err_d = 1'b1;
                     end
                  end
               endcase
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase

      errcnt_d = errcnt_q;
      if (err_d && (errcnt_q != 8'hFF)) begin
         errcnt_d = errcnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         cmd_q    <= 8'h00;
         data_q   <= 8'h00;
         sw_q     <= 8'h00;
         mask_q   <= 8'hFF;
         gate_q   <= 2'd0;
         ok_q     <= 1'b0;
         err_q    <= 1'b0;
         errcnt_q <= 8'h00;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cmd_q    <= cmd_d;
         data_q   <= data_d;
         sw_q     <= sw_d;
         mask_q   <= mask_d;
         gate_q   <= gate_d;
         ok_q     <= ok_d;
         err_q    <= err_d;
         errcnt_q <= errcnt_d;
      end
   end

   assign sw_out    = sw_q;
   assign chan_mask = mask_q;
   assign gate_sel  = gate_q;
   assign cmd_ok    = ok_q;
   assign cmd_err   = err_q;
   assign err_count = errcnt_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: each frame pushes its expected outcome,
// a negedge monitor pops and compares on every cmd_ok/cmd_err pulse.
module tb_uart_cmd_parser;

   localparam int unsigned TO  = 9600;
   localparam logic [7:0]  HDR = 8'hA5;

   typedef struct packed {
      logic       ok;
      logic       err;
      logic [7:0] sw;
      logic [7:0] mask;
      logic [1:0] gate;
      logic [7:0] cnt;
   } exp_t;

   logic       clk_in = 1'b0;
   logic       reset  = 1'b0;
   logic [7:0] sw_out, chan_mask, err_count;
   logic [1:0] gate_sel;
   logic       cmd_ok, cmd_err;

   int checks = 0;
   int errors = 0;

   exp_t sb[$];
   logic [7:0] m_sw   = 8'h00;
   logic [7:0] m_mask = 8'hFF;
   logic [1:0] m_gate = 2'd0;
   logic [7:0] m_cnt  = 8'h00;

   uart_cmd_parser_if rx_bus ();

   uart_cmd_parser #(
      .HEADER         (HDR),
      .TIMEOUT_CYCLES (TO),
      .CNT_W          (14)
   ) dut (
      .clk_in    (clk_in),
      .reset     (reset),
      .rx        (rx_bus),
      .sw_out    (sw_out),
      .chan_mask (chan_mask),
      .gate_sel  (gate_sel),
      .cmd_ok    (cmd_ok),
      .cmd_err   (cmd_err),
      .err_count (err_count)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Pulse monitor: any pulse with an empty scoreboard is unexpected.
   always @(negedge clk_in) begin
      exp_t obs;
      exp_t expv;
      if (reset && (cmd_ok || cmd_err)) begin
         obs = {cmd_ok, cmd_err, sw_out, chan_mask, gate_sel, err_count};
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse got=%h expected no pulse", obs);
         end else begin
            expv = sb.pop_front();
            if (obs !== expv) begin
               errors++;
               $display("FAIL pulse_result got=%h expected=%h", obs, expv);
            end
         end
      end
   end

   task automatic put(input logic [7:0] b);
      rx_bus.rx_data  = b;
      rx_bus.rx_valid = 1'b1;
      @(posedge clk_in);
      #1;
      rx_bus.rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      rx_bus.rx_valid = 1'b0;
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic push_err();
      m_cnt = (m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1;
      sb.push_back({1'b0, 1'b1, m_sw, m_mask, m_gate, m_cnt});
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] s);
      logic [7:0] sum;
      sum = c + d;
      if ((s == sum) && (c <= 8'h03)) begin
         if (c == 8'h01) m_sw = d;
         if (c == 8'h02) m_mask = d;
         if (c == 8'h03) m_gate = d[1:0];
         sb.push_back({1'b1, 1'b0, m_sw, m_mask, m_gate, m_cnt});
      end else begin
         push_err();
      end
      put(HDR);
      put(c);
      put(d);
      put(s);
   endtask

   task automatic test_reset();
      rx_bus.rx_valid = 1'b0;
      rx_bus.rx_data  = 8'h00;
      reset = 1'b0;
      #23;
      checks++;
      if ({cmd_ok, cmd_err, sw_out, chan_mask, gate_sel, err_count} !== {2'b00, 8'h00, 8'hFF, 2'd0, 8'h00}) begin
         errors++;
         $display("FAIL reset_values got=%b_%b_%h_%h_%h_%h expected=0_0_00_ff_0_00",
                  cmd_ok, cmd_err, sw_out, chan_mask, gate_sel, err_count);
      end
      @(posedge clk_in);
      #1;
      reset = 1'b1;
      idle(2);
      checks++;
      if ({sw_out, chan_mask, gate_sel, err_count} !== {8'h00, 8'hFF, 2'd0, 8'h00}) begin
         errors++;
         $display("FAIL post_reset got=%h_%h_%h_%h expected=00_ff_0_00",
                  sw_out, chan_mask, gate_sel, err_count);
      end
   endtask

   task automatic test_write_sw();
      send_frame(8'h01, 8'h3C, 8'h3D);
      idle(3);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL write_sw_drain pending=%0d expected=0", sb.size());
      end
      checks++;
      if (sw_out !== 8'h3C) begin
         errors++;
         $display("FAIL write_sw got=%h expected=3c", sw_out);
      end
   endtask

   task automatic test_back_to_back();
      send_frame(8'h02, 8'hF0, 8'hF2);
      send_frame(8'h03, 8'h06, 8'h09);
      send_frame(8'h00, 8'h12, 8'h12);
      idle(3);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL b2b_drain pending=%0d expected=0", sb.size());
      end
      checks++;
      if ({chan_mask, gate_sel} !== {8'hF0, 2'd2}) begin
         errors++;
         $display("FAIL b2b_regs got=%h_%h expected=f0_2", chan_mask, gate_sel);
      end
   endtask

   task automatic test_errors();
      send_frame(8'h01, 8'h55, 8'h00);
      idle(2);
      send_frame(8'h07, 8'h01, 8'h08);
      idle(3);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL errors_drain pending=%0d expected=0", sb.size());
      end
      checks++;
      if ({sw_out, err_count} !== {8'h3C, 8'd2}) begin
         errors++;
         $display("FAIL errors_regs got=%h_%h expected=3c_02", sw_out, err_count);
      end
   endtask

   task automatic test_timeout();
      push_err();
      put(HDR);
      put(8'h01);
      idle(TO);
      idle(2);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL timeout_pulse pending=%0d expected=0", sb.size());
      end
      send_frame(8'h01, 8'h11, 8'h12);
      idle(3);
      checks++;
      if (sw_out !== 8'h11) begin
         errors++;
         $display("FAIL timeout_recover got=%h expected=11", sw_out);
      end
      // Data byte lands on the terminal count cycle and must win.
      m_sw = 8'h22;
      sb.push_back({1'b1, 1'b0, m_sw, m_mask, m_gate, m_cnt});
      put(HDR);
      put(8'h01);
      idle(TO - 1);
      put(8'h22);
      put(8'h23);
      idle(3);
      checks++;
      if ({sb.size() == 0, sw_out, err_count} !== {1'b1, 8'h22, 8'd3}) begin
         errors++;
         $display("FAIL timeout_terminal got=%0d_%h_%h expected=1_22_03",
                  sb.size() == 0, sw_out, err_count);
      end
   endtask

   task automatic test_junk();
      put(8'h00);
      put(8'hFF);
      put(8'h3C);
      send_frame(8'h01, 8'h3C, 8'h3D);
      idle(3);
      checks++;
      if ({sb.size() == 0, sw_out, err_count} !== {1'b1, 8'h3C, 8'd3}) begin
         errors++;
         $display("FAIL junk got=%0d_%h_%h expected=1_3c_03", sb.size() == 0, sw_out, err_count);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 300; i++) begin
         send_frame(8'h01, 8'h55, 8'h00);
      end
      idle(3);
      checks++;
      if ({sb.size() == 0, err_count, sw_out} !== {1'b1, 8'hFF, 8'h3C}) begin
         errors++;
         $display("FAIL saturation got=%0d_%h_%h expected=1_ff_3c", sb.size() == 0, err_count, sw_out);
      end
   endtask

   task automatic test_reset_midframe();
      send_frame(8'h02, 8'h81, 8'h83);
      idle(2);
      put(HDR);
      put(8'h02);
      reset = 1'b0;
      #2;
      checks++;
      if ({cmd_ok, cmd_err, sw_out, chan_mask, gate_sel, err_count} !== {2'b00, 8'h00, 8'hFF, 2'd0, 8'h00}) begin
         errors++;
         $display("FAIL midframe_reset got=%b_%b_%h_%h_%h_%h expected=0_0_00_ff_0_00",
                  cmd_ok, cmd_err, sw_out, chan_mask, gate_sel, err_count);
      end
      m_sw   = 8'h00;
      m_mask = 8'hFF;
      m_gate = 2'd0;
      m_cnt  = 8'h00;
      idle(3);
      reset = 1'b1;
      idle(1);
      send_frame(8'h02, 8'h0F, 8'h11);
      idle(3);
      checks++;
      if ({sb.size() == 0, chan_mask, sw_out, err_count} !== {1'b1, 8'h0F, 8'h00, 8'h00}) begin
         errors++;
         $display("FAIL midframe_next got=%0d_%h_%h_%h expected=1_0f_00_00",
                  sb.size() == 0, chan_mask, sw_out, err_count);
      end
   endtask

   initial begin
      test_reset();
      test_write_sw();
      test_back_to_back();
      test_errors();
      test_timeout();
      test_junk();
      test_saturation();
      test_reset_midframe();
      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
